tt_um_serial_adder: RTL and testbench

// - Bit-serial WIDTH-bit adder built around the team's half-adder cell:
//   two half-adders plus an OR gate form a full adder, and one carry flip-flop is reused every cycle.
// - Feeds the half-adder datapath: captures operand bytes from ui_in, then streams operand bits LSB-first.
// - Returns the WIDTH-bit sum on uo_out and the carry on uio_out[5].
// - Sits as a Tiny Tapeout user tile: standard tt_um pinout, one clock domain.

---
 rtl/tt_um_serial_adder.sv | 146 ++++++++++++++
 tb/tb_tt_um_serial_adder.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tt_um_serial_adder.sv
// tt_um_serial_adder: bit-serial WIDTH-bit adder for a Tiny Tapeout tile.
// Two half-adders and an OR form one full adder. A single carry flop is reused every cycle.
// Operands are captured from ui_in on load strobes. Their bits are then streamed LSB-first.
//
// Ports:
//   clk      clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      tile enable; all state holds while low
//   ui_in    operand byte, sampled on a load pulse
//   uio_in   [0] load_a, [1] load_b, [2] start (asynchronous pins, synchronised here)
//   uo_out   last completed sum, zero-extended
//   uio_out  [7] busy, [6] done, [5] carry_out, [4:0] zero
//   uio_oe   constant 8'b1110_0000

module tt_um_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Strobe synchronisers and rising-edge detectors
    logic [2:0] sync1_q, sync2_q, dly_q;
    logic [2:0] pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            dly_q   <= '0;
        end else if (ena) begin
            sync1_q <= uio_in[2:0];
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign pulse = sync2_q & ~dly_q;

    logic load_a, load_b, start;
    assign load_a = pulse[0];
    assign load_b = pulse[1];
    assign start  = pulse[2];

    // Datapath state
    state_e             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH-1:0]   a_sh_q, b_sh_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic [CntW-1:0]    cnt_q;
    logic               carry_q;
    logic               cout_q;
    logic               busy_q;
    logic               done_q;

    // A load arriving together with start must be visible to the run it starts
    logic [WIDTH-1:0] op_byte, a_new, b_new;
    assign op_byte = ui_in[WIDTH-1:0];
    assign a_new   = load_a ? op_byte : a_q;
    assign b_new   = load_b ? op_byte : b_q;

    // Full adder from two half-adders plus an OR
    logic ha1_s, ha1_c, ha2_s, ha2_c, sum_bit, carry_nxt;
    assign ha1_s     = a_sh_q[0] ^ b_sh_q[0];
    assign ha1_c     = a_sh_q[0] & b_sh_q[0];
    assign ha2_s     = ha1_s ^ carry_q;
    assign ha2_c     = ha1_s & carry_q;
    assign sum_bit   = ha2_s;
    assign carry_nxt = ha1_c | ha2_c;

    logic [WIDTH-1:0] acc_nxt;
    assign acc_nxt = {sum_bit, acc_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (ena) begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (load_a) a_q <= op_byte;
                    if (load_b) b_q <= op_byte;
                    if (start) begin
                        state_q <= StRun;
                        carry_q <= 1'b0;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        a_sh_q  <= a_new;
                        b_sh_q  <= b_new;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end else if (state_q == StDone && (load_a || load_b)) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                    end
                end
                StRun: begin
                    // Strobes are dropped here, not queued
                    acc_q   <= acc_nxt;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    carry_q <= carry_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LastBit) begin
                        state_q  <= StDone;
                        result_q <= acc_nxt;
                        cout_q   <= carry_nxt;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uo_out  = 8'(result_q);
    assign uio_out = {busy_q, done_q, cout_q, 5'b0_0000};
    assign uio_oe  = 8'b1110_0000;

    logic unused_inputs;
    assign unused_inputs = ^{uio_in[7:3], ui_in};

endmodule

// File: tb/tb_tt_um_serial_adder.sv
// Directed-vector bench for tt_um_serial_adder (WIDTH = 8).
module tb_tt_um_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    int n_vec = 0;
    int n_err = 0;

    tt_um_serial_adder #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse one strobe pin for a clock and hold ui_in until the load has landed
    task automatic strobe(input int idx, input logic [7:0] data);
        @(negedge clk);
        ui_in       = data;
        uio_in[idx] = 1'b1;
        @(negedge clk);
        uio_in[idx] = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Raise start before edge E0; lat = number of edges seen (E0 counted as 1) until done.
    // hold: negedge index at which the start pin drops; inject: pulse start+load_a mid-run;
    // freeze: drop ena for three edges mid-run.
    task automatic start_and_wait(input int hold, input bit inject, input bit freeze,
                                  output int lat);
        lat = -1;
        @(negedge clk);
        uio_in[2] = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == hold) uio_in[2] = 1'b0;
            if (inject && n == 4) begin
                ui_in     = 8'hFF;
                uio_in[0] = 1'b1;
                uio_in[2] = 1'b1;
            end
            if (inject && n == 5) begin
                uio_in[0] = 1'b0;
                uio_in[2] = 1'b0;
            end
            if (freeze && n == 5) ena = 1'b0;
            if (freeze && n == 8) ena = 1'b1;
            if (n > 2 && uio_out[6]) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic add_vec(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] sum, input logic cy);
        int lat;
        strobe(0, a);
        strobe(1, b);
        start_and_wait(1, 1'b0, 1'b0, lat);
        // done rises after edge E10 = 11th edge counted from E0
        check_eq({tag, " latency"}, lat, 11);
        check_eq({tag, " sum"}, uo_out, sum);
        check_eq({tag, " carry"}, uio_out[5], cy);
        check_eq({tag, " busy"}, uio_out[7], 1'b0);
    endtask

    initial begin
        int  lat;
        bit  busy_seen;

        // Reset state
        #1;
        check_eq("rst uo_out", uo_out, 8'h00);
        check_eq("rst uio_out", uio_out, 8'h00);
        check_eq("rst uio_oe", uio_oe, 8'hE0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle busy", uio_out[7], 1'b0);
        check_eq("idle done", uio_out[6], 1'b0);

        // Main function, with explicit busy window check
        strobe(0, 8'h5A);
        strobe(1, 8'h33);
        @(negedge clk);
        uio_in[2] = 1'b1;
        repeat (2) @(negedge clk);
        uio_in[2] = 1'b0;
        check_eq("pre-run busy", uio_out[7], 1'b0);
        @(negedge clk);
        check_eq("run busy", uio_out[7], 1'b1);
        check_eq("run holds old sum", uo_out, 8'h00);
        repeat (7) @(negedge clk);
        check_eq("last bit busy", uio_out[7], 1'b1);
        check_eq("last bit not done", uio_out[6], 1'b0);
        @(negedge clk);
        check_eq("5A+33 done", uio_out[6], 1'b1);
        check_eq("5A+33 sum", uo_out, 8'h8D);
        check_eq("5A+33 carry", uio_out[5], 1'b0);
        repeat (5) @(negedge clk);
        check_eq("done persists", uio_out[6], 1'b1);

        add_vec("FF+01", 8'hFF, 8'h01, 8'h00, 1'b1);
        add_vec("FF+FF", 8'hFF, 8'hFF, 8'hFE, 1'b1);
        add_vec("00+00", 8'h00, 8'h00, 8'h00, 1'b0);

        // Strobes during RUN are dropped
        strobe(0, 8'h10);
        strobe(1, 8'h20);
        start_and_wait(1, 1'b1, 1'b0, lat);
        check_eq("inject latency", lat, 11);
        check_eq("inject sum", uo_out, 8'h30);
        repeat (3) @(negedge clk);
        check_eq("inject still done", uio_out[6], 1'b1);
        start_and_wait(1, 1'b0, 1'b0, lat);
        check_eq("restart latency", lat, 11);
        check_eq("restart sum (A kept)", uo_out, 8'h30);

        // Held start level gives one addition
        strobe(0, 8'h01);
        check_eq("load in DONE clears done", uio_out[6], 1'b0);
        strobe(1, 8'h02);
        start_and_wait(20, 1'b0, 1'b0, lat);
        check_eq("held latency", lat, 11);
        check_eq("held sum", uo_out, 8'h03);
        repeat (20 - lat) @(negedge clk);
        uio_in[2] = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (uio_out[7]) busy_seen = 1'b1;
        end
        check_eq("held single add", busy_seen, 1'b0);

        // ena freeze mid-run
        strobe(0, 8'h5A);
        strobe(1, 8'h33);
        start_and_wait(1, 1'b0, 1'b1, lat);
        check_eq("freeze latency", lat, 14);
        check_eq("freeze sum", uo_out, 8'h8D);
        check_eq("freeze carry", uio_out[5], 1'b0);

        // Reset at bit 4 of a run
        strobe(0, 8'hFF);
        strobe(1, 8'hFF);
        @(negedge clk);
        uio_in[2] = 1'b1;
        @(negedge clk);
        uio_in[2] = 1'b0;
        repeat (6) @(negedge clk);
        check_eq("pre-abort busy", uio_out[7], 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("abort uo_out", uo_out, 8'h00);
        check_eq("abort uio_out", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("abort stays idle", uio_out[7:6], 2'b00);
        add_vec("12+34", 8'h12, 8'h34, 8'h46, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
